// File: rtl/delay_writer_pkg.sv
// Shared definitions for the delay-line writer and its readers (chorus, taps).
package delay_writer_pkg;
  localparam int unsigned ADDR_W_DEF = 13;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_AVAIL,
    WRITE,
    DONE
  } state_t;
endpackage

// File: rtl/delay_writer_ring_ptr.sv
// Delay-line write pointer with a sticky flag marking the first full lap.
module ring_ptr
  import delay_writer_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  output logic [ADDR_W-1:0] ptr,
  output logic              wrapped
);
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      wrapped <= 1'b0;
    end else if (advance) begin
      ptr <= ptr + ADDR_W'(1);
      if (ptr == '1) wrapped <= 1'b1;
    end
  end
endmodule

// File: rtl/delay_writer.sv
// Appends one sample per granted turn to the SRAM-backed delay line,
// with a bounded wait on the SRAM controller.
module delay_writer
  import delay_writer_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              my_turn,
  input  logic [DATA_W-1:0] data_in,
  input  logic              sram_available,
  input  logic              sram_write_finish,
  output logic              sram_wr,
  output logic [ADDR_W-1:0] sram_offset,
  output logic [DATA_W-1:0] sram_data_out,
  output logic              done,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              wrapped,
  output logic              error
);
  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             advance;

  // The pointer only moves on a genuine completion; a timeout leaves it alone.
  assign advance = (state == WRITE) && sram_write_finish;

  ring_ptr #(.ADDR_W(ADDR_W)) u_ring_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .ptr     (wr_ptr),
    .wrapped (wrapped)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sram_wr       <= 1'b0;
      sram_offset   <= '0;
      sram_data_out <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
      cnt           <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cs && my_turn) begin
            sram_data_out <= data_in;
            cnt           <= '0;
            if (sram_available) begin
              state       <= WRITE;
              sram_wr     <= 1'b1;
              sram_offset <= wr_ptr;
            end else begin
              state <= WAIT_AVAIL;
            end
          end
        end
        WAIT_AVAIL: begin
          if (sram_available) begin
            state       <= WRITE;
            sram_wr     <= 1'b1;
            sram_offset <= wr_ptr;
            cnt         <= '0;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WRITE: begin
          if (sram_write_finish) begin
            sram_wr <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            sram_wr <= 1'b0;
            error   <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          // done was raised on entry; it falls here via the default above.
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_delay_writer.sv
// Directed bench for delay_writer with a behavioural SRAM controller.
module tb_delay_writer;
  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        my_turn;
  logic [15:0] data_in;
  logic        sram_available;
  logic        sram_write_finish;
  logic        sram_wr;
  logic [12:0] sram_offset;
  logic [15:0] sram_data_out;
  logic        done;
  logic [12:0] wr_ptr;
  logic        wrapped;
  logic        error;

  logic [15:0] mem [8192];
  int  total = 0;
  int  bad   = 0;
  int  lat   = 0;
  int  lat_cnt = 0;
  bit  suppress = 1'b0;
  bit  stray = 1'b0;

  always #5 clk = ~clk;

  delay_writer #(.ADDR_W(13), .DATA_W(16), .TIMEOUT(255)) dut (
    .clk               (clk),
    .rst               (rst),
    .cs                (cs),
    .my_turn           (my_turn),
    .data_in           (data_in),
    .sram_available    (sram_available),
    .sram_write_finish (sram_write_finish),
    .sram_wr           (sram_wr),
    .sram_offset       (sram_offset),
    .sram_data_out     (sram_data_out),
    .done              (done),
    .wr_ptr            (wr_ptr),
    .wrapped           (wrapped),
    .error             (error)
  );

  // SRAM controller model: completes a request lat cycles after it appears.
  initial begin
    sram_write_finish = 1'b0;
    forever begin
      @(negedge clk);
      if (sram_write_finish) begin
        sram_write_finish = 1'b0;
      end else if (stray) begin
        sram_write_finish = 1'b1;
        stray = 1'b0;
      end else if (sram_wr && !suppress) begin
        if (lat_cnt >= lat) begin
          sram_write_finish = 1'b1;
          mem[sram_offset] = sram_data_out;
          lat_cnt = 0;
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input int maxc, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < maxc) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Back-to-back writes of values 0..cnt-1 with my_turn held high.
  task automatic burst(input int cnt, output int misses, output bit wrap_early,
                       output bit wrap_last);
    int n;
    bit seen;
    misses = 0;
    wrap_early = 1'b0;
    wrap_last = 1'b0;
    cs = 1'b1;
    my_turn = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      data_in = 16'(i);
      wait_done(20, n, seen);
      if (!seen) misses++;
      if (i < cnt - 1 && wrapped) wrap_early = 1'b1;
      if (i == cnt - 1) wrap_last = wrapped;
    end
    my_turn = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int misses;
    int cnt_a;
    int cnt_b;
    bit seen;
    bit w_early;
    bit w_last;
    rst = 1'b1;
    cs = 1'b0;
    my_turn = 1'b0;
    data_in = '0;
    sram_available = 1'b1;
    for (int i = 0; i < 8192; i++) mem[i] = 16'hdead;
    do_reset();
    check("rst_wr", 32'(sram_wr), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ptr", 32'(wr_ptr), 32'd0);
    check("rst_flags", {30'd0, wrapped, error}, 32'd0);
    check("rst_bus", {3'd0, sram_offset, sram_data_out}, 32'd0);

    // Single write of 4; data_in disturbed after acceptance.
    data_in = 16'd4;
    cs = 1'b1;
    my_turn = 1'b1;
    @(posedge clk); #1;
    check("t1_wr", 32'(sram_wr), 32'd1);
    check("t1_off", 32'(sram_offset), 32'd0);
    my_turn = 1'b0;
    data_in = 16'd99;
    wait_done(50, n, seen);
    check("t1_seen", 32'(seen), 32'd1);
    check("t1_lat", 32'(n), 32'd2);
    check("t1_mem", 32'(mem[0]), 32'd4);
    check("t1_ptr", 32'(wr_ptr), 32'd1);
    @(negedge clk);
    check("t1_pulse", 32'(done), 32'd0);

    // Full lap of the delay line.
    do_reset();
    burst(8192, misses, w_early, w_last);
    check("wrap_miss", 32'(misses), 32'd0);
    check("wrap_early", 32'(w_early), 32'd0);
    check("wrap_set", 32'(w_last), 32'd1);
    check("wrap_ptr", 32'(wr_ptr), 32'd0);
    misses = 0;
    for (int i = 0; i < 8192; i++) if (mem[i] !== 16'(i)) misses++;
    check("wrap_mem", 32'(misses), 32'd0);
    check("wrap_m5k", 32'(mem[5000]), 32'd5000);

    // SRAM busy for 10 cycles at the start of a transaction.
    sram_available = 1'b0;
    data_in = 16'h1234;
    my_turn = 1'b1;
    @(posedge clk); #1;
    my_turn = 1'b0;
    cnt_a = 0;
    repeat (10) begin
      @(negedge clk);
      if (sram_wr) cnt_a++;
    end
    check("busy_nowr", 32'(cnt_a), 32'd0);
    sram_available = 1'b1;
    @(posedge clk); #1;
    check("busy_wr", 32'(sram_wr), 32'd1);
    wait_done(50, n, seen);
    check("busy_done", 32'(seen), 32'd1);
    check("busy_mem", 32'(mem[0]), 32'h1234);
    check("busy_ptr", 32'(wr_ptr), 32'd1);
    check("busy_wrapped", 32'(wrapped), 32'd1);
    @(negedge clk);

    // Completion withheld: timeout path.
    suppress = 1'b1;
    data_in = 16'd5;
    my_turn = 1'b1;
    @(posedge clk); #1;
    my_turn = 1'b0;
    wait_done(400, n, seen);
    check("to_seen", 32'(seen), 32'd1);
    check("to_cycles", 32'(n), 32'd257);
    check("to_err", 32'(error), 32'd1);
    check("to_ptr", 32'(wr_ptr), 32'd1);
    check("to_wr", 32'(sram_wr), 32'd0);
    suppress = 1'b0;
    @(negedge clk);

    // Reset in the middle of a long write at wr_ptr=100.
    do_reset();
    check("rst2_err", 32'(error), 32'd0);
    burst(100, misses, w_early, w_last);
    check("r100_ptr", 32'(wr_ptr), 32'd100);
    lat = 20;
    data_in = 16'h0bad;
    my_turn = 1'b1;
    @(posedge clk); #1;
    my_turn = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_wr", 32'(sram_wr), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_wr", 32'(sram_wr), 32'd0);
    check("mid_rst_ptr", 32'(wr_ptr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt_a = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) cnt_a++;
    end
    check("mid_nodone", 32'(cnt_a), 32'd0);
    lat = 0;

    // Stray completion pulse while idle.
    stray = 1'b1;
    repeat (4) @(negedge clk);
    check("stray_ptr", 32'(wr_ptr), 32'd0);

    // Block disabled while the turn is offered.
    cs = 1'b0;
    my_turn = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    repeat (50) begin
      @(negedge clk);
      if (sram_wr) cnt_a++;
      if (done) cnt_b++;
    end
    check("cs0_nowr", 32'(cnt_a), 32'd0);
    check("cs0_nodone", 32'(cnt_b), 32'd0);

    // cs dropped mid-write must not abort.
    lat = 3;
    cs = 1'b1;
    data_in = 16'd7;
    @(posedge clk); #1;
    my_turn = 1'b0;
    cs = 1'b0;
    wait_done(50, n, seen);
    check("csdrop_done", 32'(seen), 32'd1);
    check("csdrop_mem", 32'(mem[0]), 32'd7);
    check("csdrop_ptr", 32'(wr_ptr), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
